// File: rtl/display_scan_capture.sv
// Receive-side monitor for a two-digit multiplexed 7-segment display.
// Rebuilds the shown tens/units value from the shared segment bus and enables.
module display_scan_capture #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_unidad,
    input  logic       en_decena,
    input  logic [6:0] seg,
    output logic [3:0] unidad,
    output logic [3:0] decena,
    output logic       valor_valido,
    output logic       actualizado,
    output logic       error_patron,
    output logic       timeout
);
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_MAX  = '1;
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX      = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic          r_en_u, r_en_d, r_pen_u, r_pen_d;
    logic [6:0]    r_seg, r_pseg;
    logic [SW-1:0] r_set_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [1:0]    r_state;
    logic          r_dig;
    logic          r_conf;
    logic          r_have_u, r_have_d;
    logic [3:0]    r_sh_u, r_sh_d;
    logic [3:0]    r_unidad, r_decena;
    logic          r_valid, r_upd, r_err, r_tout;

    logic          w_same, w_conf, w_one, w_dig, w_cap, w_legal;
    logic [3:0]    w_val;
    logic [SW-1:0] w_cnt;
    logic [1:0]    w_nstate;
    logic          w_ndig;

    assign w_same = ({r_en_u, r_en_d, r_seg} == {r_pen_u, r_pen_d, r_pseg});
    assign w_conf = r_en_u & r_en_d;
    assign w_one  = r_en_u ^ r_en_d;
    assign w_dig  = r_en_d;

    // w_cnt counts how many consecutive identical samples the current one completes, minus one
    assign w_cnt = !w_same ? '0 : ((r_set_cnt == SETTLE_MAX) ? r_set_cnt : r_set_cnt + 1'b1);
    assign w_cap = (r_state == S_SETTLE) && w_one && (w_dig == r_dig) && (w_cnt >= SETTLE_LAST);

    always_comb begin
        w_val   = 4'd0;
        w_legal = 1'b1;
        case (r_seg)
            7'h3F: w_val = 4'd0;
            7'h06: w_val = 4'd1;
            7'h5B: w_val = 4'd2;
            7'h4F: w_val = 4'd3;
            7'h66: w_val = 4'd4;
            7'h6D: w_val = 4'd5;
            7'h7D: w_val = 4'd6;
            7'h07: w_val = 4'd7;
            7'h7F: w_val = 4'd8;
            7'h6F: w_val = 4'd9;
            default: w_legal = 1'b0;
        endcase
    end

    // No enable or both enables both park the FSM in IDLE
    always_comb begin
        w_nstate = r_state;
        w_ndig   = r_dig;
        if (!w_one) begin
            w_nstate = S_IDLE;
        end else if (r_state == S_IDLE || w_dig != r_dig) begin
            w_nstate = S_SETTLE;
            w_ndig   = w_dig;
        end else if (w_cap) begin
            w_nstate = S_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_u    <= 1'b0;
            r_en_d    <= 1'b0;
            r_seg     <= '0;
            r_pen_u   <= 1'b0;
            r_pen_d   <= 1'b0;
            r_pseg    <= '0;
            r_set_cnt <= '0;
            r_to_cnt  <= '0;
            r_state   <= S_IDLE;
            r_dig     <= 1'b0;
            r_conf    <= 1'b0;
            r_have_u  <= 1'b0;
            r_have_d  <= 1'b0;
            r_sh_u    <= '0;
            r_sh_d    <= '0;
            r_unidad  <= '0;
            r_decena  <= '0;
            r_valid   <= 1'b0;
            r_upd     <= 1'b0;
            r_err     <= 1'b0;
            r_tout    <= 1'b0;
        end else begin
            r_en_u    <= en_unidad;
            r_en_d    <= en_decena;
            r_seg     <= seg;
            r_pen_u   <= r_en_u;
            r_pen_d   <= r_en_d;
            r_pseg    <= r_seg;
            r_set_cnt <= w_cnt;
            r_state   <= w_nstate;
            r_dig     <= w_ndig;
            r_conf    <= w_conf;
            r_err     <= (w_conf & ~r_conf) | (w_cap & ~w_legal);
            r_upd     <= 1'b0;

            if (r_have_u && r_have_d) begin
                r_unidad <= r_sh_u;
                r_decena <= r_sh_d;
                r_valid  <= 1'b1;
                r_upd    <= 1'b1;
                r_have_u <= 1'b0;
                r_have_d <= 1'b0;
            end

            if (r_to_cnt == TO_LAST) begin
                r_tout   <= 1'b1;
                r_valid  <= 1'b0;
                r_have_u <= 1'b0;
                r_have_d <= 1'b0;
            end

            // Placed last so a capture's flag set wins over any clear above
            if (w_cap) begin
                r_to_cnt <= '0;
                if (w_legal) begin
                    r_tout <= 1'b0;
                    if (r_dig) begin
                        r_sh_d   <= w_val;
                        r_have_d <= 1'b1;
                    end else begin
                        r_sh_u   <= w_val;
                        r_have_u <= 1'b1;
                    end
                end
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign unidad       = r_unidad;
    assign decena       = r_decena;
    assign valor_valido = r_valid;
    assign actualizado  = r_upd;
    assign error_patron = r_err;
    assign timeout      = r_tout;
endmodule

// File: doc/display_scan_capture.md
Name: display_scan_capture

Overview:
- Receive end of the two-digit multiplexed 7-segment display interface: watches the time-multiplexed digit enables and shared segment bus, and rebuilds the displayed decimal value (tens, units).
- Sits beside the display controller, on the same segment and enable nets, for self-check and loopback of the Gray-decoder output path.
- Frames are judged complete only after both digits are captured with a stable, legal pattern.
- Detects illegal patterns, enable conflicts and a stalled scan.

Parameters:
- SETTLE_CYCLES, 8: consecutive identical samples (same enable, same segments) required before a digit is captured; minimum 2.
- TIMEOUT_CYCLES, 200000: clk cycles without any digit capture before the scan is declared stalled. This is 4 ms at 50 MHz, i.e. 4x the 1 kHz mux period.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- en_unidad  in  1  units digit enable, active-high
- en_decena  in  1  tens digit enable, active-high
- seg  in  7  segment pattern, active-high; bit0=a … bit6=g
- unidad  out  4  captured units value, BCD
- decena  out  4  captured tens value, BCD
- valor_valido  out  1  unidad/decena hold a complete, current frame
- actualizado  out  1  1-cycle pulse when a new frame is loaded
- error_patron  out  1  1-cycle pulse on illegal pattern or enable conflict
- timeout  out  1  scan stalled; level signal

Behaviour:
- Reset (rst=1 at a clk edge): unidad=0, decena=0, valor_valido=0, actualizado=0, error_patron=0, timeout=0. Reset also clears all internal state: sample registers, counters, have_u, have_d, shadow registers. Reset mid-frame discards any partial capture.
- Input sampling: en_unidad, en_decena and seg are registered once. All decisions below use the registered copies.
- Decode table (seg hex → value): 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9. Any other pattern, including 0x00, is illegal.
- Settle counter: clears whenever the sampled {enables, seg} differs from the previous sample. Otherwise it increments, saturating.
- FSM states and transitions:
  - IDLE: no enable active. Go to SETTLE when exactly one enable is active.
  - SETTLE: one enable active and the counter is running.
    - Enable drops before settling → IDLE, nothing captured.
    - Enable switches to the other digit → restart SETTLE.
    - Counter reaches SETTLE_CYCLES-1 with an unchanged sample → capture this cycle, then go to HOLD.
  - HOLD: digit already captured in this enable window. Segment changes are ignored. Go to IDLE when the enable drops, or straight to SETTLE if the other enable rises in the same sample. Only one capture is allowed per enable window.
  - Both enables high in one sample: error_patron pulses once on entry to the conflict. FSM goes to IDLE, and no capture occurs until the conflict clears.
- Capture:
  - Legal pattern: write the shadow register of the active digit and set have_u or have_d.
  - Illegal pattern: pulse error_patron and leave the flag and shadow unchanged.
  - Recapturing the same digit before the other one overwrites the shadow.
- Frame completion:
  - The cycle after both have_u and have_d are set: unidad/decena ← shadows, valor_valido=1, actualizado=1 for exactly one cycle, both flags cleared.
  - Latency from the raw seg input edge to actualizado: 1 (input register) + SETTLE_CYCLES + 1 cycles, counted on the second digit.
  - Frames load even if the value is unchanged.
- Timeout:
  - The counter clears on every capture, legal or illegal, and otherwise increments.
  - At TIMEOUT_CYCLES-1: timeout=1, valor_valido=0, flags cleared. unidad and decena keep their last values.
  - timeout clears on the next legal capture. valor_valido returns only on the next completed frame.
- Counter widths: $clog2 of the parameter plus 1. Counters saturate and never wrap.

Test Plan (bench uses SETTLE_CYCLES=4, TIMEOUT_CYCLES=100):
- Reset then alternate en_unidad with seg=0x4F and en_decena with seg=0x06, 20 cycles each → after the tens window, unidad=3, decena=1, valor_valido=1, and actualizado is a single 1-cycle pulse.
- seg toggles between 0x6D and 0x7D every 2 cycles while en_unidad=1, then holds 0x7D → capture only after 4 stable samples, and unidad=6 after the next tens capture.
- en_decena=1 with seg=0x49 held → error_patron pulses once, no frame loads, valor_valido stays at its previous value.
- en_unidad and en_decena both 1 for 10 cycles → one error_patron pulse, no capture, FSM resumes normal capture on the next single enable.
- Normal frames (unidad=9, decena=0), then enables held low for 120 cycles → timeout=1 at the 100th idle cycle, valor_valido=0, outputs still 9/0. Next legal capture clears timeout.
- rst=1 asserted during SETTLE of the second digit → all outputs 0 on the next edge, and the following frame requires fresh captures of both digits.
